// File: rtl/piece_ctrl_pkg.sv
// Shared types and defaults for the active-piece controller.
//   shape_t    : the seven tetromino codes
//   orient_t   : clockwise orientation, UP=00 .. LEFT=11
//   pc_state_t : controller FSM states
//   cmd_kind_t : what produced the candidate currently being checked
// Helper functions implement the 8-bit shape LFSR (taps 8,6,5,4) and its raw shape mapping.
package piece_ctrl_pkg;

  localparam int unsigned BoardWDef = 10;
  localparam int unsigned BoardHDef = 20;

  typedef enum logic [2:0] {
    ShLine   = 3'd0,
    ShSquare = 3'd1,
    ShT      = 3'd2,
    ShL      = 3'd3,
    ShJ      = 3'd4,
    ShZ      = 3'd5,
    ShS      = 3'd6
  } shape_t;

  typedef enum logic [1:0] {
    OrUp    = 2'd0,
    OrRight = 2'd1,
    OrDown  = 2'd2,
    OrLeft  = 2'd3
  } orient_t;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StCheck,
    StWait,
    StLock,
    StOver
  } pc_state_t;

  typedef enum logic [2:0] {
    KindSpawn,
    KindDown,
    KindLeft,
    KindRight,
    KindRot
  } cmd_kind_t;

  // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1 (maximal length).
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Low three bits select the shape; the unused code 7 folds onto 0..3 via bits [4:3].
  function automatic logic [2:0] lfsr_shape(input logic [7:0] v);
    return (v[2:0] == 3'b111) ? {1'b0, v[4:3]} : v[2:0];
  endfunction

endpackage

// File: rtl/piece_ctrl_if.sv
// Candidate-check handshake between the piece controller and the collision checker.
//   chk_req     : candidate valid, held until chk_valid
//   cand_*      : candidate shape / orientation / column / row
//   chk_valid   : one-cycle response strobe from the checker
//   chk_fits    : qualified by chk_valid, 1 = candidate is collision-free
// Modports: master = piece controller, slave = collision checker.
interface piece_ctrl_if #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20
) ();

  logic                       chk_req;
  logic [2:0]                 cand_shape;
  logic [1:0]                 cand_orient;
  logic [$clog2(BOARD_W)-1:0] cand_x;
  logic [$clog2(BOARD_H)-1:0] cand_y;
  logic                       chk_valid;
  logic                       chk_fits;

  modport master (
    output chk_req,
    output cand_shape,
    output cand_orient,
    output cand_x,
    output cand_y,
    input  chk_valid,
    input  chk_fits
  );

  modport slave (
    input  chk_req,
    input  cand_shape,
    input  cand_orient,
    input  cand_x,
    input  cand_y,
    output chk_valid,
    output chk_fits
  );

endinterface

// File: rtl/piece_ctrl_shape_picker.sv
// Pseudo-random shape source for new pieces.
//   clk, rst : clock, asynchronous active-high reset
//   next_i   : the shape on shape_o is consumed this cycle (spawn)
//   clr_i    : start of a new game
//   shape_o  : shape code 0..6 for the next spawn
// The LFSR free-runs every cycle. With SEVEN_BAG_EN defined, a used-code mask makes every
// run of seven consecutive spawns a permutation of all seven shapes.
module shape_picker
  import piece_ctrl_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       next_i,
  input  logic       clr_i,
  output logic [2:0] shape_o
);

  logic [7:0] lfsr_q;
  logic [2:0] raw_shape;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign raw_shape = lfsr_shape(lfsr_q);

`ifdef SEVEN_BAG_EN
  logic [6:0] used_q, used_d, used_upd;
  logic [2:0] pick, probe;
  logic       found;

  // Walk forward mod 7 from the raw pick to the first code not yet dealt in this bag.
  always_comb begin
    pick  = raw_shape;
    probe = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 7; k++) begin
      probe = 3'((32'(raw_shape) + k) % 32'd7);
      if (!found && !used_q[probe]) begin
        pick  = probe;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    used_upd = used_q | (7'b1 << pick);
    used_d   = used_q;
    if (clr_i) begin
      used_d = '0;
    end else if (next_i) begin
      used_d = (used_upd == 7'h7F) ? 7'h00 : used_upd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q <= '0;
    end else begin
      used_q <= used_d;
    end
  end

  assign shape_o = pick;
`else
  logic unused_bag;
  assign unused_bag = next_i ^ clr_i;
  assign shape_o    = raw_shape;
`endif

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller, upstream of the shape generator.
//   clk, reset               : clock, asynchronous active-high reset
//   start                    : leave IDLE/OVER and spawn a piece
//   mv_left/mv_right/rot     : player command pulses
//   grav_tick                : gravity pulse (one row down)
//   chk                      : candidate/collision-check handshake (master side)
//   cur_shape/cur_orient     : committed piece, feeds the shape generator
//   cur_x/cur_y              : committed position
//   lock                     : one-cycle pulse when the piece locks
//   game_over                : high from a failed spawn until start or reset
// Optional feature: SEVEN_BAG_EN selects 7-bag shape dealing in the picker.
module piece_ctrl
  import piece_ctrl_pkg::*;
#(
  parameter int unsigned BOARD_W   = BoardWDef,
  parameter int unsigned BOARD_H   = BoardHDef,
  parameter int unsigned SPAWN_X   = 3,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mv_left,
  input  logic                       mv_right,
  input  logic                       rot,
  input  logic                       grav_tick,
  piece_ctrl_if.master               chk,
  output logic [2:0]                 cur_shape,
  output logic [1:0]                 cur_orient,
  output logic [$clog2(BOARD_W)-1:0] cur_x,
  output logic [$clog2(BOARD_H)-1:0] cur_y,
  output logic                       lock,
  output logic                       game_over
);

  localparam int unsigned XW = $clog2(BOARD_W);
  localparam int unsigned YW = $clog2(BOARD_H);
  localparam logic [XW-1:0] SpawnX = XW'(SPAWN_X);
  localparam logic [YW-1:0] YMax   = YW'(BOARD_H - 1);

  pc_state_t       state_q, state_d;
  cmd_kind_t       kind_q, kind_d;
  logic [2:0]      cur_shape_q, cur_shape_d, cand_shape_q, cand_shape_d;
  logic [1:0]      cur_orient_q, cur_orient_d, cand_orient_q, cand_orient_d;
  logic [XW-1:0]   cur_x_q, cur_x_d, cand_x_q, cand_x_d;
  logic [YW-1:0]   cur_y_q, cur_y_d, cand_y_q, cand_y_d;
  logic            chk_req_q, chk_req_d;
  logic            lock_q, lock_d;
  logic            game_over_q, game_over_d;
  logic            pend_q, pend_d;
  logic            pick_next, pick_clr;
  logic [2:0]      pick_shape;

  shape_picker #(
    .LFSR_SEED (LFSR_SEED)
  ) u_picker (
    .clk     (clk),
    .rst     (reset),
    .next_i  (pick_next),
    .clr_i   (pick_clr),
    .shape_o (pick_shape)
  );

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    cur_shape_d   = cur_shape_q;
    cur_orient_d  = cur_orient_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    cand_shape_d  = cand_shape_q;
    cand_orient_d = cand_orient_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    chk_req_d     = chk_req_q;
    lock_d        = 1'b0;
    game_over_d   = game_over_q;
    pend_d        = pend_q;
    pick_next     = 1'b0;
    pick_clr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pick_clr = 1'b1;
          state_d  = StSpawn;
        end
      end

      StSpawn: begin
        if (grav_tick) pend_d = 1'b1;
        pick_next     = 1'b1;
        cand_shape_d  = pick_shape;
        cand_orient_d = OrUp;
        cand_x_d      = SpawnX;
        cand_y_d      = '0;
        kind_d        = KindSpawn;
        chk_req_d     = 1'b1;
        state_d       = StCheck;
      end

      StCheck: begin
        if (grav_tick) pend_d = 1'b1;
        if (chk.chk_valid) begin
          chk_req_d = 1'b0;
          if (chk.chk_fits) begin
            cur_shape_d  = cand_shape_q;
            cur_orient_d = cand_orient_q;
            cur_x_d      = cand_x_q;
            cur_y_d      = cand_y_q;
            state_d      = StWait;
          end else if (kind_q == KindDown) begin
            lock_d  = 1'b1;
            state_d = StLock;
          end else if (kind_q == KindSpawn) begin
            game_over_d = 1'b1;
            state_d     = StOver;
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        // Candidate starts from the committed piece; only the commanded field changes.
        cand_shape_d  = cur_shape_q;
        cand_orient_d = cur_orient_q;
        cand_x_d      = cur_x_q;
        cand_y_d      = cur_y_q;
        if (grav_tick || pend_q) begin
          pend_d    = 1'b0;
          cand_y_d  = (cur_y_q == YMax) ? cur_y_q : cur_y_q + YW'(1);
          kind_d    = KindDown;
          chk_req_d = 1'b1;
          state_d   = StCheck;
        end else if (rot) begin
          cand_orient_d = cur_orient_q + 2'd1;
          kind_d        = KindRot;
          chk_req_d     = 1'b1;
          state_d       = StCheck;
        end else if (mv_left) begin
          // Left wall is resolved here; a move off column 0 never reaches the checker.
          if (cur_x_q != '0) begin
            cand_x_d  = cur_x_q - XW'(1);
            kind_d    = KindLeft;
            chk_req_d = 1'b1;
            state_d   = StCheck;
          end
        end else if (mv_right) begin
          cand_x_d  = cur_x_q + XW'(1);
          kind_d    = KindRight;
          chk_req_d = 1'b1;
          state_d   = StCheck;
        end
      end

      StLock: begin
        // Ticks owed to the locked piece are dropped; a tick arriving now counts for the next.
        pend_d  = grav_tick;
        state_d = StSpawn;
      end

      StOver: begin
        if (start) begin
          game_over_d = 1'b0;
          pick_clr    = 1'b1;
          state_d     = StSpawn;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      kind_q        <= KindSpawn;
      cur_shape_q   <= '0;
      cur_orient_q  <= '0;
      cur_x_q       <= SpawnX;
      cur_y_q       <= '0;
      cand_shape_q  <= '0;
      cand_orient_q <= '0;
      cand_x_q      <= SpawnX;
      cand_y_q      <= '0;
      chk_req_q     <= 1'b0;
      lock_q        <= 1'b0;
      game_over_q   <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      cur_shape_q   <= cur_shape_d;
      cur_orient_q  <= cur_orient_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      cand_shape_q  <= cand_shape_d;
      cand_orient_q <= cand_orient_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      chk_req_q     <= chk_req_d;
      lock_q        <= lock_d;
      game_over_q   <= game_over_d;
      pend_q        <= pend_d;
    end
  end

  assign chk.chk_req     = chk_req_q;
  assign chk.cand_shape  = cand_shape_q;
  assign chk.cand_orient = cand_orient_q;
  assign chk.cand_x      = cand_x_q;
  assign chk.cand_y      = cand_y_q;

  assign cur_shape  = cur_shape_q;
  assign cur_orient = cur_orient_q;
  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign lock       = lock_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl: acts as the collision checker, predicts every candidate
// into a scoreboard queue when the stimulus is driven and compares on each chk_req.
module tb_piece_ctrl;

  typedef struct packed {
    logic [2:0] shape;
    logic [1:0] orient;
    logic [3:0] x;
    logic [4:0] y;
  } cand_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, mv_left = 1'b0, mv_right = 1'b0, rot = 1'b0, grav_tick = 1'b0;
  logic [2:0] cur_shape;
  logic [1:0] cur_orient;
  logic [3:0] cur_x;
  logic [4:0] cur_y;
  logic lock, game_over;

  int total = 0;
  int bad = 0;
  cand_t sb[$];

  logic [7:0] m_lfsr;
  logic [2:0] e_shape;
  logic [1:0] e_or;
  logic [3:0] e_x;
  logic [4:0] e_y;
  logic [7:0] l_now;
  logic [6:0] seen;

  piece_ctrl_if #(.BOARD_W(10), .BOARD_H(20)) chk_if ();

  piece_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mv_left    (mv_left),
    .mv_right   (mv_right),
    .rot        (rot),
    .grav_tick  (grav_tick),
    .chk        (chk_if.master),
    .cur_shape  (cur_shape),
    .cur_orient (cur_orient),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .lock       (lock),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_step(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  function automatic logic [2:0] m_map(input logic [7:0] v);
    logic [2:0] lo;
    lo = v[2:0];
    if (lo == 3'd7) lo = {1'b0, v[4:3]};
    return lo;
  endfunction

  // Reference LFSR: free-runs like the spec says, reset to the seed.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= m_step(m_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [1:0] o, input logic [3:0] x,
                      input logic [4:0] y);
    cand_t c;
    c.shape = s; c.orient = o; c.x = x; c.y = y;
    sb.push_back(c);
  endtask

  task automatic send(input logic l, input logic r, input logic ro, input logic g);
    mv_left = l; mv_right = r; rot = ro; grav_tick = g;
    tick();
    mv_left = 1'b0; mv_right = 1'b0; rot = 1'b0; grav_tick = 1'b0;
  endtask

  // Bounded wait for a request, then pop the predicted candidate and compare.
  task automatic wait_req(input string tag);
    int n;
    cand_t e;
    n = 0;
    while (chk_if.chk_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".req"}, 32'(chk_if.chk_req), 32'd1);
    check({tag, ".sb_size"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
`ifndef SEVEN_BAG_EN
      check({tag, ".shape"}, 32'(chk_if.cand_shape), 32'(e.shape));
`endif
      check({tag, ".orient"}, 32'(chk_if.cand_orient), 32'(e.orient));
      check({tag, ".x"}, 32'(chk_if.cand_x), 32'(e.x));
      check({tag, ".y"}, 32'(chk_if.cand_y), 32'(e.y));
    end
  endtask

  task automatic respond(input logic fits);
    chk_if.chk_valid = 1'b1;
    chk_if.chk_fits  = fits;
    tick();
    chk_if.chk_valid = 1'b0;
    chk_if.chk_fits  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_if.chk_valid = 1'b0;
    chk_if.chk_fits  = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.cur_shape", 32'(cur_shape), 32'd0);
    check("rst.cur_orient", 32'(cur_orient), 32'd0);
    check("rst.cur_x", 32'(cur_x), 32'd3);
    check("rst.cur_y", 32'(cur_y), 32'd0);
    check("rst.chk_req", 32'(chk_if.chk_req), 32'd0);
    check("rst.lock", 32'(lock), 32'd0);
    check("rst.game_over", 32'(game_over), 32'd0);
    reset = 1'b0;

    // First spawn: SPAWN cycle sees the LFSR one step after this cycle's value.
    l_now   = m_lfsr;
    e_shape = m_map(m_step(l_now));
    push(e_shape, 2'd0, 4'd3, 5'd0);
    start = 1'b1; tick(); start = 1'b0;
    wait_req("spawn1");
    repeat (3) tick();
    check("hold.req", 32'(chk_if.chk_req), 32'd1);
    check("hold.x", 32'(chk_if.cand_x), 32'd3);
    respond(1'b1);
    e_or = 2'd0; e_x = 4'd3; e_y = 5'd0;
    check("spawn1.req_drop", 32'(chk_if.chk_req), 32'd0);
    check("spawn1.cur_x", 32'(cur_x), 32'(e_x));
    check("spawn1.cur_y", 32'(cur_y), 32'(e_y));
`ifndef SEVEN_BAG_EN
    check("spawn1.cur_shape", 32'(cur_shape), 32'(e_shape));
`endif
    check("spawn1.game_over", 32'(game_over), 32'd0);

    // Three left moves down to column 0.
    for (int i = 0; i < 3; i++) begin
      e_x = e_x - 4'd1;
      push(e_shape, e_or, e_x, e_y);
      send(1'b1, 1'b0, 1'b0, 1'b0);
      wait_req("left");
      respond(1'b1);
      check("left.cur_x", 32'(cur_x), 32'(e_x));
    end

    // Left at the wall: rejected locally.
    send(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("left_wall.req", 32'(chk_if.chk_req), 32'd0);
      tick();
    end
    check("left_wall.cur_x", 32'(cur_x), 32'd0);

    // Four fitting rotations wrap the orientation.
    for (int i = 0; i < 4; i++) begin
      e_or = e_or + 2'd1;
      push(e_shape, e_or, e_x, e_y);
      send(1'b0, 1'b0, 1'b1, 1'b0);
      wait_req("rot");
      respond(1'b1);
      check("rot.cur_orient", 32'(cur_orient), 32'(e_or));
    end

    // Rejected rotation leaves orientation alone.
    push(e_shape, e_or + 2'd1, e_x, e_y);
    send(1'b0, 1'b0, 1'b1, 1'b0);
    wait_req("rot_rej");
    respond(1'b0);
    tick();
    check("rot_rej.cur_orient", 32'(cur_orient), 32'(e_or));
    check("rot_rej.req", 32'(chk_if.chk_req), 32'd0);

    // Gravity beats rotate; a tick during CHECK queues a second down move.
    push(e_shape, e_or, e_x, e_y + 5'd1);
    send(1'b0, 1'b0, 1'b1, 1'b1);
    wait_req("grav_rot");
    send(1'b0, 1'b0, 1'b0, 1'b1);
    push(e_shape, e_or, e_x, e_y + 5'd2);
    respond(1'b1);
    e_y = e_y + 5'd1;
    check("grav_rot.cur_orient", 32'(cur_orient), 32'(e_or));
    check("grav_rot.cur_y", 32'(cur_y), 32'(e_y));
    wait_req("pend_down");
    respond(1'b1);
    e_y = e_y + 5'd1;
    check("pend_down.cur_y", 32'(cur_y), 32'(e_y));

    // Fall to row 18.
    while (e_y < 5'd18) begin
      push(e_shape, e_or, e_x, e_y + 5'd1);
      send(1'b0, 1'b0, 1'b0, 1'b1);
      wait_req("fall");
      respond(1'b1);
      e_y = e_y + 5'd1;
    end
    check("fall.cur_y", 32'(cur_y), 32'd18);

    // Blocked down move: lock pulse, then a fresh spawn two cycles later.
    push(e_shape, e_or, e_x, 5'd19);
    send(1'b0, 1'b0, 1'b0, 1'b1);
    wait_req("lock_down");
    l_now = m_lfsr;
    push(m_map(m_step(m_step(l_now))), 2'd0, 4'd3, 5'd0);
    respond(1'b0);
    check("lock.pulse", 32'(lock), 32'd1);
    check("lock.cur_y", 32'(cur_y), 32'd18);
    check("lock.cur_x", 32'(cur_x), 32'(e_x));
    tick();
    check("lock.one_cycle", 32'(lock), 32'd0);
    wait_req("spawn_after_lock");

    // Spawn fails: game over, no further requests.
    respond(1'b0);
    check("over.game_over", 32'(game_over), 32'd1);
    send(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("over.req", 32'(chk_if.chk_req), 32'd0);
      tick();
    end
    check("over.hold", 32'(game_over), 32'd1);

    // Restart from OVER.
    l_now   = m_lfsr;
    e_shape = m_map(m_step(l_now));
    push(e_shape, 2'd0, 4'd3, 5'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("restart.game_over", 32'(game_over), 32'd0);
    wait_req("spawn_restart");
    respond(1'b1);
    e_or = 2'd0; e_x = 4'd3; e_y = 5'd0;
    check("restart.cur_x", 32'(cur_x), 32'd3);
    check("restart.cur_y", 32'(cur_y), 32'd0);
`ifndef SEVEN_BAG_EN
    check("restart.cur_shape", 32'(cur_shape), 32'(e_shape));
`endif

    // Reset in the middle of a check; the late response must be ignored.
    push(e_shape, e_or, e_x + 4'd1, e_y);
    send(1'b0, 1'b1, 1'b0, 1'b0);
    wait_req("right");
    #2 reset = 1'b1;
    #1;
    check("midrst.req", 32'(chk_if.chk_req), 32'd0);
    tick();
    reset = 1'b0;
    respond(1'b1);
    check("late_valid.req", 32'(chk_if.chk_req), 32'd0);
    check("late_valid.cur_x", 32'(cur_x), 32'd3);
    check("late_valid.cur_shape", 32'(cur_shape), 32'd0);
    check("late_valid.lock", 32'(lock), 32'd0);
    check("sb.drained", 32'(sb.size()), 32'd0);

`ifdef SEVEN_BAG_EN
    // Seven consecutive spawns deal each shape once.
    seen = '0;
    push(3'd0, 2'd0, 4'd3, 5'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wait_req("bag_spawn");
      seen = seen | (7'b1 << chk_if.cand_shape);
      respond(1'b1);
      if (i < 6) begin
        push(3'd0, 2'd0, 4'd3, 5'd1);
        send(1'b0, 1'b0, 1'b0, 1'b1);
        wait_req("bag_down");
        push(3'd0, 2'd0, 4'd3, 5'd0);
        respond(1'b0);
      end
    end
    check("bag.all_shapes", 32'(seen), 32'h7F);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
